pipeline_register: RTL and testbench
====================================

// Module: pipeline_register
// PURPOSE
//   Single-stage valid/ready pipeline register (register slice) for breaking timing paths on a streaming bus.
//   Accepts one word per cycle from an upstream producer and presents it downstream one cycle later.
//   Full throughput, with no loss, duplication or reordering under arbitrary backpressure.
//   Sits between any two streaming blocks that use the standard valid/ready handshake.
// PARAMETERS
//   DATA_WIDTH   32   payload width in bits (>=1)
// PORTS
//   clk        in   1           single clock; all logic on rising edge
//   rst_n      in   1           synchronous, active-low reset
//   in_data    in   DATA_WIDTH  upstream payload
//   in_valid   in   1           upstream word valid
//   in_ready   out  1           stage can accept a word this cycle
//   out_data   out  DATA_WIDTH  downstream payload (registered)
//   out_valid  out  1           out_data holds a valid word (registered)
//   out_ready  in   1           downstream accepts this cycle
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-low (rst_n sampled on the clk rising edge).
//   - Transfers: input transfer = in_valid & in_ready at a rising edge; output transfer = out_valid & out_ready.
//   - Reset (rst_n=0 at an edge): out_valid=0, out_data='0, skid state cleared.
//     in_ready is forced 0 while rst_n=0.
//     The first input transfer is possible at the first edge with rst_n=1.
//   - Latency: a word accepted at edge N appears on out_data/out_valid after edge N (visible in cycle N+1).
//   - Base mode in_ready: in_ready = !out_valid | out_ready (combinational from out_ready).
//   - Register update on each edge with rst_n=1:
//     * in transfer: out_data<=in_data, out_valid<=1.
//     * else if out transfer: out_valid<=0; out_data holds its value.
//     * else: hold both.
//   - Simultaneous in+out transfer while full: the old word leaves and the new word loads in the same edge.
//     Result: 1 word/cycle with out_ready held high.
//   - Stall: while out_valid=1 and out_ready=0, out_data and out_valid stay stable.
//     in_ready=0, and in_data/in_valid are ignored.
//   - in_valid may drop without a transfer; no word is consumed unless in_ready=1.
//   - out_data is don't-care while out_valid=0; the implementation keeps the last value.
//   - Reset mid-operation: any held word is discarded; out_valid=0 on the cycle after the reset edge.
// CONFIGURATION
//   - Macro PIPELINE_REGISTER_SKID_EN.
//   - Defined: 2-entry skid buffer. in_ready is a flop with no combinational path from out_ready.
//     States EMPTY(0 words), BUSY(1), FULL(2).
//     * in_ready=1 in EMPTY/BUSY, 0 in FULL.
//     * In transfer while output stalled in BUSY: the word goes to the skid register, ->FULL.
//     * Out transfer in FULL: skid word moves to output, ->BUSY.
//     * In+out transfer in BUSY: stay BUSY.
//     * Out transfer without an in transfer in BUSY: ->EMPTY.
//     * Latency stays 1 cycle when not stalled; order is preserved.
//   - Undefined: base mode only, with no skid register and no state machine.
// STRUCTURE
//   - Package pipeline_register_pkg: typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t.
//     Also localparam DATA_WIDTH_DEFAULT = 32.
//   - Sub-module pipeline_register_skid (skid data register + state machine), instantiated only under PIPELINE_REGISTER_SKID_EN.
//   - Top level: output register and handshake glue.
// TESTING
//   - Run each scenario in both modes. Scoreboard: queue of input transfers vs output transfers.
//     At the end of each scenario, counts must match and values must match in order.
//   1 Single word: out_ready=1, in_data=0xDEADBEEF, in_valid for 1 cycle.
//     -> out_valid=1 with 0xDEADBEEF the next cycle; exactly 1 word received.
//   2 Backpressure: out_ready=0, send 0xCAFEBABE then hold 0x12345678 valid for 3 cycles, then out_ready=1.
//     -> in_ready=0 once the stage is full; out_data stays 0xCAFEBABE while stalled.
//     -> Outputs in order: 0xCAFEBABE, then 0x12345678.
//   3 Streaming: out_ready=1, in_data=0..9 on consecutive cycles.
//     -> 10 outputs 0..9, one per cycle, no bubbles.
//   4 Alternating: in_data=100..109 continuous, out_ready toggles 0/1 each cycle, then held at 1.
//     -> 10 outputs 100..109 in order.
//   5 Random: 20 cycles of random in_valid/in_data and random out_ready, then drain with out_ready=1.
//     -> Sent and received queues are identical.
//   6 Reset mid-op: load 0xABCDEF00 with out_ready=0, then pulse rst_n low for 3 cycles.
//     -> out_valid=0 after release; the word is never output.

Source files
------------

// File: rtl/pipeline_register_pkg.sv
// Shared types and defaults for the pipeline_register slice.
package pipeline_register_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;

    // Occupancy of the skid variant: words held across output and skid registers
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipeline_register_skid.sv
// Skid data register and occupancy FSM for the pipeline_register slice.
// Tells the top-level output register when to load (and from where) or drop.
// in_ready is registered, so it has no combinational path from out_ready.
module pipeline_register_skid
    import pipeline_register_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  out_ready,
    output logic                  in_ready,
    output logic                  load_en,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  drop_en
);

    skid_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  in_ready_q, in_ready_d;
    logic                  in_xfer;

    // The flop is ready out of reset; rst_n masks it so nothing is accepted during reset
    assign in_ready = in_ready_q & rst_n;
    assign in_xfer  = in_valid & in_ready;

    // State register: occupancy, skid word and registered ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next state: track how many words the slice holds after this edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_xfer) state_d = BUSY;
            BUSY: begin
                if (in_xfer && !out_ready)      state_d = FULL;
                else if (!in_xfer && out_ready) state_d = EMPTY;
            end
            FULL:    if (out_ready) state_d = BUSY;
            default: state_d = EMPTY;
        endcase
    end

    // Outputs: steer the output register, capture into skid when stalled
    always_comb begin
        load_en     = 1'b0;
        load_data   = in_data;
        drop_en     = 1'b0;
        skid_data_d = skid_data_q;
        in_ready_d  = (state_d != FULL);
        case (state_q)
            EMPTY: load_en = in_xfer;
            BUSY: begin
                if (in_xfer) begin
                    if (out_ready) load_en     = 1'b1;
                    else           skid_data_d = in_data;
                end else if (out_ready) begin
                    drop_en = 1'b1;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load_en   = 1'b1;
                    load_data = skid_data_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_register.sv
// Single-stage valid/ready register slice.
// Build option: define PIPELINE_REGISTER_SKID_EN for a 2-entry skid variant with a
// registered in_ready; otherwise in_ready = !out_valid | out_ready.
module pipeline_register
    import pipeline_register_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  drop_en;

`ifdef PIPELINE_REGISTER_SKID_EN
    pipeline_register_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .load_en   (load_en),
        .load_data (load_data),
        .drop_en   (drop_en)
    );
`else
    // Handshake glue: accept whenever the output slot is free or being emptied
    always_comb begin
        in_ready  = rst_n & (~out_valid_q | out_ready);
        load_en   = in_valid & in_ready;
        load_data = in_data;
        drop_en   = out_valid_q & out_ready;
    end
`endif

    // Output register next value: a load wins over a drop; data holds otherwise
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load_en) begin
            out_data_d  = load_data;
            out_valid_d = 1'b1;
        end else if (drop_en) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipeline_register.sv
// Self-checking bench for pipeline_register (either build of PIPELINE_REGISTER_SKID_EN).
// Reference model: a queue of words held by the slice; its size gives out_valid and
// in_ready, its head gives out_data.
module tb_pipeline_register;

    localparam int W = 32;
`ifdef PIPELINE_REGISTER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;

    always #5 clk = ~clk;

    pipeline_register #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           mon_en = 1'b0;
    bit           acc = 1'b0;
    logic [W-1:0] q[$];
    logic [W-1:0] expq[$];
    logic [W-1:0] obs[$];
    int           obs_cyc[$];

    // Per-cycle monitor at the falling edge: check against the model, then apply the
    // transfers that the coming rising edge will perform (inputs are stable until then).
    initial begin
        bit exp_v;
        bit exp_r;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                exp_v = (q.size() > 0);
                exp_r = rst_n && (SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
                checks++;
                if (out_valid !== exp_v) begin
                    errors++;
                    $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (out_data !== q[0]) begin
                        errors++;
                        $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, q[0]);
                    end
                end
                checks++;
                if (in_ready !== exp_r) begin
                    errors++;
                    $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_r);
                end
                if (rst_n) begin
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        obs.push_back(out_data);
                        obs_cyc.push_back(cyc);
                    end
                    acc = in_valid && exp_r;
                    if (exp_v && out_ready) expq.push_back(q.pop_front());
                    if (acc) q.push_back(in_data);
                end else begin
                    q.delete();
                    acc = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs.delete();
        obs_cyc.delete();
        expq.delete();
    endtask

    // Present one word and hold it until the model says it was accepted (bounded)
    task automatic send_word(input logic [W-1:0] d, output bit ok);
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            step();
            ok = acc;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() != 0; n++) step();
        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d exp=0", q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        step();
        mon_en = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h r=%b exp v=0 d=0 r=0", out_valid, out_data, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        clear_logs();
        out_ready = 1'b1;
        in_data = 32'hDEADBEEF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_latency got v=%b d=%h exp v=1 d=deadbeef", out_valid, out_data);
        end
        drain();
        checks++;
        if (obs.size() != 1 || obs[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_count got n=%0d exp n=1 word deadbeef", obs.size());
        end
        $display("test_single received %0d word(s)", obs.size());
    endtask

    task automatic test_backpressure();
        bit ok;
        bit got;
        clear_logs();
        out_ready = 1'b0;
        send_word(32'hCAFEBABE, ok);
        in_data = 32'h12345678;
        in_valid = 1'b1;
        got = 1'b0;
        repeat (3) begin
            step();
            if (acc) begin
                got = 1'b1;
                in_valid = 1'b0;
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_full got=%b exp=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL bp_stall_hold got v=%b d=%h exp v=1 d=cafebabe", out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 10 && !got; n++) begin
            step();
            got = acc;
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (!ok || !got || obs.size() != 2 || obs[0] !== 32'hCAFEBABE || obs[1] !== 32'h12345678) begin
            errors++;
            $display("FAIL bp_order got n=%0d first=%h exp n=2 cafebabe,12345678",
                     obs.size(), (obs.size() > 0) ? obs[0] : 32'h0);
        end
        $display("test_backpressure received %0d word(s)", obs.size());
    endtask

    task automatic test_streaming();
        bit ok;
        int bad = 0;
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_word(W'(i), ok);
            if (!ok) bad++;
        end
        drain();
        checks++;
        if (bad != 0 || obs.size() != 10) begin
            errors++;
            $display("FAIL stream_count got n=%0d stalls=%0d exp n=10 stalls=0", obs.size(), bad);
        end else begin
            foreach (obs[i]) begin
                checks++;
                if (obs[i] !== W'(i)) begin
                    errors++;
                    $display("FAIL stream_word[%0d] got=%h exp=%h", i, obs[i], W'(i));
                end
            end
            checks++;
            if (obs_cyc[9] - obs_cyc[0] != 9) begin
                errors++;
                $display("FAIL stream_bubbles span got=%0d exp=9", obs_cyc[9] - obs_cyc[0]);
            end
        end
        $display("test_streaming received %0d word(s)", obs.size());
    endtask

    task automatic test_alternating();
        int idx = 0;
        clear_logs();
        for (int c = 0; c < 60 && idx < 10; c++) begin
            out_ready = (c % 2 == 1);
            in_valid  = 1'b1;
            in_data   = W'(100 + idx);
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (idx != 10 || obs.size() != 10) begin
            errors++;
            $display("FAIL alt_count got sent=%0d recv=%0d exp 10/10", idx, obs.size());
        end else begin
            foreach (obs[i]) begin
                checks++;
                if (obs[i] !== W'(100 + i)) begin
                    errors++;
                    $display("FAIL alt_word[%0d] got=%0d exp=%0d", i, obs[i], 100 + i);
                end
            end
        end
        $display("test_alternating received %0d word(s)", obs.size());
    endtask

    task automatic test_random();
        clear_logs();
        repeat (20) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();
        checks++;
        if (obs.size() != expq.size()) begin
            errors++;
            $display("FAIL rand_count got=%0d exp=%0d", obs.size(), expq.size());
        end else begin
            foreach (obs[i]) begin
                checks++;
                if (obs[i] !== expq[i]) begin
                    errors++;
                    $display("FAIL rand_word[%0d] got=%h exp=%h", i, obs[i], expq[i]);
                end
            end
        end
        $display("test_random received %0d word(s)", obs.size());
    endtask

    task automatic test_reset_midop();
        bit ok;
        clear_logs();
        out_ready = 1'b0;
        send_word(32'hABCDEF00, ok);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release got v=%b r=%b loaded=%b exp v=0 r=1 loaded=1", out_valid, in_ready, ok);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got v=%b exp=0", out_valid);
        end
        drain();
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL midreset_discard got n=%0d exp=0", obs.size());
        end
        $display("test_reset_midop received %0d word(s)", obs.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_alternating();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
